// File: rtl/bck_slot_scheduler_pkg.sv
// Shared status codes and slot-context state for the backward-extension pipeline.
// Scheduler, arbiter and pipeline stages all use the same encodings.
package smem_pkg;

   localparam logic [5:0] F_IDLE  = 6'h00;
   localparam logic [5:0] F_INI   = 6'h01;
   localparam logic [5:0] F_RUN   = 6'h02;
   localparam logic [5:0] F_END   = 6'h03;
   localparam logic [5:0] BCK_INI = 6'h04;
   localparam logic [5:0] BCK_RUN = 6'h05;
   localparam logic [5:0] BCK_END = 6'h06;
   localparam logic [5:0] BUBBLE  = 6'h30;
   localparam logic [5:0] DONE    = 6'h3f;

   typedef enum logic [1:0] {
      FREE     = 2'd0,
      INI_PEND = 2'd1,
      INFLIGHT = 2'd2,
      RUN_PEND = 2'd3
   } slot_state_t;

endpackage

// File: rtl/bck_slot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr_i and wraps.
// Returns the one-hot grant, its index and whether anything was granted.
module rr_arbiter #(
   parameter int N = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      // N is a power of two, so the index wraps through natural truncation
      for (int i = 0; i < N; i++) begin
         cand = ptr_i + IW'(i + 1);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bck_slot_scheduler.sv
// Shares the backward-extension pipeline among NUM_SLOTS reads, issuing one status token
// per unstalled cycle and re-issuing each read when its token returns from the tail.
module bck_slot_scheduler
   import smem_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int RD_W      = 9,
   parameter int SZ_W      = 7,
   localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              req_valid_i,
   input  logic [RD_W-1:0]   req_read_num_i,
   input  logic [SZ_W-1:0]   req_forward_size_i,
   output logic              req_ready_o,
   input  logic              ret_valid_i,
   input  logic [SLOT_W-1:0] ret_slot_i,
   input  logic              ret_done_i,
   output logic [5:0]        issue_status_o,
   output logic [SLOT_W-1:0] issue_slot_o,
   output logic [RD_W-1:0]   issue_read_num_o,
   output logic [SZ_W-1:0]   issue_forward_size_o,
   output logic              done_valid_o,
   output logic [RD_W-1:0]   done_read_num_o,
   output logic              busy_o,
   output logic              err_o
);

   slot_state_t         state_q [NUM_SLOTS];
   logic [RD_W-1:0]     id_q    [NUM_SLOTS];
   logic [SZ_W-1:0]     size_q  [NUM_SLOTS];
   logic [SLOT_W-1:0]   ptr_q;
   logic [SLOT_W-1:0]   ptr_d;

   logic [5:0]          issue_status_q;
   logic [SLOT_W-1:0]   issue_slot_q;
   logic [RD_W-1:0]     issue_read_num_q;
   logic [SZ_W-1:0]     issue_forward_size_q;
   logic                done_valid_q;
   logic [RD_W-1:0]     done_read_num_q;
   logic                err_q;

   logic [NUM_SLOTS-1:0] free_vec;
   logic [NUM_SLOTS-1:0] elig_vec;
   logic [NUM_SLOTS-1:0] gnt_vec;
   logic [SLOT_W-1:0]    gnt_idx;
   logic                 gnt_valid;
   logic [SLOT_W-1:0]    free_idx;
   logic                 free_any;
   logic                 accept;
   logic                 ret_legal;
   logic                 grant_fire;

   always_comb begin
      free_vec = '0;
      elig_vec = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         free_vec[i] = (state_q[i] == FREE);
         elig_vec[i] = (state_q[i] == INI_PEND) || (state_q[i] == RUN_PEND);
      end
   end

   // Scanning downward leaves the lowest free index as the final assignment
   always_comb begin
      free_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_vec[i]) free_idx = SLOT_W'(i);
      end
   end

   rr_arbiter #(.N(NUM_SLOTS)) u_arb (
      .req_i   (elig_vec),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt_vec),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   assign free_any   = |free_vec;
   assign accept     = req_valid_i && free_any;
   assign ret_legal  = ret_valid_i && (state_q[ret_slot_i] == INFLIGHT);
   assign grant_fire = !stall_i && gnt_valid && (gnt_vec != '0);
   assign ptr_d      = grant_fire ? gnt_idx : ptr_q;

   // Accept targets a FREE slot, grant a pending one and a legal return an INFLIGHT one,
   // so the three slot updates below never touch the same slot in one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            state_q[i] <= FREE;
            id_q[i]    <= '0;
            size_q[i]  <= '0;
         end
         ptr_q                <= SLOT_W'(NUM_SLOTS - 1);
         issue_status_q       <= BUBBLE;
         issue_slot_q         <= '0;
         issue_read_num_q     <= '0;
         issue_forward_size_q <= '0;
         done_valid_q         <= 1'b0;
         done_read_num_q      <= '0;
         err_q                <= 1'b0;
      end else begin
         done_valid_q <= 1'b0;
         ptr_q        <= ptr_d;

         if (accept) begin
            state_q[free_idx] <= INI_PEND;
            id_q[free_idx]    <= req_read_num_i;
            size_q[free_idx]  <= req_forward_size_i;
         end

         if (ret_valid_i) begin
            if (ret_legal) begin
               if (ret_done_i) begin
                  state_q[ret_slot_i] <= FREE;
                  done_valid_q        <= 1'b1;
                  done_read_num_q     <= id_q[ret_slot_i];
               end else begin
                  state_q[ret_slot_i] <= RUN_PEND;
               end
            end else begin
               err_q <= 1'b1;
            end
         end

         if (!stall_i) begin
            if (grant_fire) begin
               state_q[gnt_idx]     <= INFLIGHT;
               issue_status_q       <= (state_q[gnt_idx] == INI_PEND) ? BCK_INI : BCK_RUN;
               issue_slot_q         <= gnt_idx;
               issue_read_num_q     <= id_q[gnt_idx];
               issue_forward_size_q <= size_q[gnt_idx];
            end else begin
               issue_status_q       <= BUBBLE;
               issue_slot_q         <= '0;
               issue_read_num_q     <= '0;
               issue_forward_size_q <= '0;
            end
         end
      end
   end

   assign req_ready_o          = free_any;
   assign busy_o               = !(&free_vec);
   assign issue_status_o       = issue_status_q;
   assign issue_slot_o         = issue_slot_q;
   assign issue_read_num_o     = issue_read_num_q;
   assign issue_forward_size_o = issue_forward_size_q;
   assign done_valid_o         = done_valid_q;
   assign done_read_num_o      = done_read_num_q;
   assign err_o                = err_q;

endmodule

// File: tb/tb_bck_slot_scheduler.sv
// Directed bench for bck_slot_scheduler: hand-computed expectations per step.
module tb_bck_slot_scheduler;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       stall_i;
   logic       req_valid_i;
   logic [8:0] req_read_num_i;
   logic [6:0] req_forward_size_i;
   logic       req_ready_o;
   logic       ret_valid_i;
   logic [2:0] ret_slot_i;
   logic       ret_done_i;
   logic [5:0] issue_status_o;
   logic [2:0] issue_slot_o;
   logic [8:0] issue_read_num_o;
   logic [6:0] issue_forward_size_o;
   logic       done_valid_o;
   logic [8:0] done_read_num_o;
   logic       busy_o;
   logic       err_o;

   int n_pass  = 0;
   int n_total = 0;

   bck_slot_scheduler #(.NUM_SLOTS(8), .RD_W(9), .SZ_W(7)) dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .stall_i              (stall_i),
      .req_valid_i          (req_valid_i),
      .req_read_num_i       (req_read_num_i),
      .req_forward_size_i   (req_forward_size_i),
      .req_ready_o          (req_ready_o),
      .ret_valid_i          (ret_valid_i),
      .ret_slot_i           (ret_slot_i),
      .ret_done_i           (ret_done_i),
      .issue_status_o       (issue_status_o),
      .issue_slot_o         (issue_slot_o),
      .issue_read_num_o     (issue_read_num_o),
      .issue_forward_size_o (issue_forward_size_o),
      .done_valid_o         (done_valid_o),
      .done_read_num_o      (done_read_num_o),
      .busy_o               (busy_o),
      .err_o                (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_issue(input string tag, input logic [5:0] st, input logic [2:0] sl,
                            input logic [8:0] id);
      chk({tag, "_status"}, 32'(issue_status_o), 32'(st));
      chk({tag, "_slot"},   32'(issue_slot_o),   32'(sl));
      chk({tag, "_id"},     32'(issue_read_num_o), 32'(id));
   endtask

   task automatic ret(input logic [2:0] sl, input logic dn);
      ret_valid_i = 1'b1;
      ret_slot_i  = sl;
      ret_done_i  = dn;
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; req_valid_i = 1'b0; req_read_num_i = '0;
      req_forward_size_i = '0; ret_valid_i = 1'b0; ret_slot_i = '0; ret_done_i = 1'b0;
      repeat (2) step();
      rst_i = 1'b0;
      step(); step();

      // 1) idle after reset
      chk("idle_status", 32'(issue_status_o), 32'h30);
      chk("idle_ready",  32'(req_ready_o), 32'd1);
      chk("idle_busy",   32'(busy_o), 32'd0);
      chk("idle_err",    32'(err_o), 32'd0);
      step();
      chk("idle_status2", 32'(issue_status_o), 32'h30);

      // 2) single read: INI, return, RUN, retire
      req_valid_i = 1'b1; req_read_num_i = 9'd5; req_forward_size_i = 7'd20;
      step();
      req_valid_i = 1'b0;
      chk("t2_busy", 32'(busy_o), 32'd1);
      step();
      chk_issue("t2_ini", 6'h04, 3'd0, 9'd5);
      chk("t2_size", 32'(issue_forward_size_o), 32'd20);
      step();
      chk("t2_bubble", 32'(issue_status_o), 32'h30);
      ret(3'd0, 1'b0);
      step();
      ret_valid_i = 1'b0;
      chk("t2_bubble2", 32'(issue_status_o), 32'h30);
      step();
      chk_issue("t2_run", 6'h05, 3'd0, 9'd5);
      ret(3'd0, 1'b1);
      step();
      ret_valid_i = 1'b0;
      chk("t2_done_v",  32'(done_valid_o), 32'd1);
      chk("t2_done_id", 32'(done_read_num_o), 32'd5);
      step();
      chk("t2_done_v0", 32'(done_valid_o), 32'd0);
      chk("t2_busy0",   32'(busy_o), 32'd0);

      // 3) three reads back-to-back, interleaved INI then RUN in slot order
      req_valid_i = 1'b1; req_read_num_i = 9'd1; req_forward_size_i = 7'd1;
      step();
      req_read_num_i = 9'd2; req_forward_size_i = 7'd2;
      step();
      chk_issue("t3_ini0", 6'h04, 3'd0, 9'd1);
      req_read_num_i = 9'd3; req_forward_size_i = 7'd3;
      step();
      chk_issue("t3_ini1", 6'h04, 3'd1, 9'd2);
      req_valid_i = 1'b0;
      step();
      chk_issue("t3_ini2", 6'h04, 3'd2, 9'd3);
      step();
      chk("t3_bubble", 32'(issue_status_o), 32'h30);
      ret(3'd0, 1'b0);
      step();
      ret(3'd1, 1'b0);
      step();
      chk_issue("t3_run0", 6'h05, 3'd0, 9'd1);
      ret(3'd2, 1'b0);
      step();
      chk_issue("t3_run1", 6'h05, 3'd1, 9'd2);
      ret_valid_i = 1'b0;
      step();
      chk_issue("t3_run2", 6'h05, 3'd2, 9'd3);
      step();
      chk("t3_no_double", 32'(issue_status_o), 32'h30);
      ret(3'd0, 1'b1); step();
      ret(3'd1, 1'b1); step();
      ret(3'd2, 1'b1); step();
      ret_valid_i = 1'b0;
      step();
      chk("t3_busy0", 32'(busy_o), 32'd0);

      // 4) fill all slots, retire slot 3, refill it
      for (int k = 0; k < 8; k++) begin
         req_valid_i = 1'b1; req_read_num_i = 9'(10 + k); req_forward_size_i = 7'(k + 1);
         step();
      end
      chk("t4_full_ready", 32'(req_ready_o), 32'd0);
      chk("t4_full_busy",  32'(busy_o), 32'd1);
      req_read_num_i = 9'd99;
      step();
      chk_issue("t4_ini7", 6'h04, 3'd7, 9'd17);
      ret(3'd3, 1'b1);
      req_read_num_i = 9'd40; req_forward_size_i = 7'd9;
      step();
      ret_valid_i = 1'b0;
      chk("t4_done_v",  32'(done_valid_o), 32'd1);
      chk("t4_done_id", 32'(done_read_num_o), 32'd13);
      chk("t4_ready",   32'(req_ready_o), 32'd1);
      step();
      req_valid_i = 1'b0;
      chk("t4_done_v0", 32'(done_valid_o), 32'd0);
      chk("t4_refull",  32'(req_ready_o), 32'd0);
      step();
      chk_issue("t4_ini3", 6'h04, 3'd3, 9'd40);
      chk("t4_size3", 32'(issue_forward_size_o), 32'd9);

      // 5) stall for five cycles while returns make slots pending
      stall_i = 1'b1;
      ret(3'd0, 1'b0); step();
      ret(3'd1, 1'b0); step();
      ret(3'd2, 1'b0); step();
      chk_issue("t5_frozen", 6'h04, 3'd3, 9'd40);
      ret(3'd5, 1'b0); step();
      ret_valid_i = 1'b0;
      step();
      chk_issue("t5_frozen2", 6'h04, 3'd3, 9'd40);
      stall_i = 1'b0;
      step();
      chk_issue("t5_run5", 6'h05, 3'd5, 9'd15);
      step();
      chk_issue("t5_run0", 6'h05, 3'd0, 9'd10);
      step();
      chk_issue("t5_run1", 6'h05, 3'd1, 9'd11);
      step();
      chk_issue("t5_run2", 6'h05, 3'd2, 9'd12);
      step();
      chk("t5_bubble", 32'(issue_status_o), 32'h30);

      // 6) illegal return sets sticky err; async reset mid-cycle
      chk("t6_err0", 32'(err_o), 32'd0);
      ret(3'd7, 1'b1);
      step();
      chk("t6_done_id", 32'(done_read_num_o), 32'd17);
      ret(3'd7, 1'b0);
      step();
      ret_valid_i = 1'b0;
      chk("t6_err1", 32'(err_o), 32'd1);
      step(); step();
      chk("t6_err_sticky", 32'(err_o), 32'd1);
      req_valid_i = 1'b1; req_read_num_i = 9'd50; req_forward_size_i = 7'd4;
      step();
      req_valid_i = 1'b0;
      step();
      chk_issue("t6_ini7", 6'h04, 3'd7, 9'd50);
      #2;
      rst_i = 1'b1;
      #1;
      chk("t6_rst_status", 32'(issue_status_o), 32'h30);
      chk("t6_rst_slot",   32'(issue_slot_o), 32'd0);
      chk("t6_rst_id",     32'(issue_read_num_o), 32'd0);
      chk("t6_rst_busy",   32'(busy_o), 32'd0);
      chk("t6_rst_ready",  32'(req_ready_o), 32'd1);
      chk("t6_rst_err",    32'(err_o), 32'd0);
      rst_i = 1'b0;
      step();
      ret(3'd2, 1'b0);
      step();
      ret_valid_i = 1'b0;
      chk("t6_stale_ret_err", 32'(err_o), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
